pcm_mc: RTL and testbench
=========================

# pcm_mc

Parametrised multi-channel PCM playback engine: byte-wide host writes fill an internal audio FIFO, and a rate accumulator driven by the audio-DAC `next_sample` strobe pops one complete frame per tick. Each frame holds `NUM_CH` samples of 8 or 16 bits, signed or unsigned. Each channel gets its own logarithmic volume. Sits between the register/bus interface and the audio mixer, replacing the fixed mono/stereo PCM path.

## Interface
- `NUM_CH`, 2, number of channels, 1..4.
- `FIFO_DEPTH`, 4096, FIFO depth in bytes; must be a power of 2 and ≥16.
- `RATE_W`, 8, width of the sample-rate register and accumulator.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `next_sample` in 1: one-cycle strobe at the DAC base rate.
- `sample_rate` in RATE_W: accumulator increment.
- `mode_16bit` in 1: 1 = 16-bit little-endian samples; 0 = 8-bit samples.
- `mode_unsigned` in 1: 1 = samples are offset-binary, and the sample MSB is inverted on assembly.
- `volume` in 4*NUM_CH: per-channel volume, channel c in bits [4c+3:4c].
- `fifo_reset` in 1: synchronous FIFO flush.
- `fifo_wrdata` in 8, `fifo_write` in 1: byte write port.
- `underrun_clr` in 1: clears `underrun`.
- `fifo_full`, `fifo_empty`, `fifo_almost_empty` out 1 each; `fifo_almost_empty` means level < FIFO_DEPTH/4.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: byte count.
- `underrun` out 1: sticky underrun flag.
- `sample_valid` out 1: one-cycle pulse in the first cycle a new value appears on `audio_out`.
- `audio_out` out 23*NUM_CH: signed scaled samples, channel c in bits [23c+22:23c].

## Operation
- **Reset:** `rst_n` low clears all registers and empties the FIFO. Reset values: `fifo_empty`=1, `fifo_almost_empty`=1, `fifo_full`=0, `fifo_level`=0, `underrun`=0, `sample_valid`=0, `audio_out`=0. The state machine goes to IDLE and the accumulator to 0.
- **Rate accumulator:**
  - On each `next_sample`, add `sample_rate` to the RATE_W-bit accumulator, wrapping modulo 2^RATE_W.
  - `tick` is a registered signal, high the cycle after the add, when accumulator bit RATE_W-1 toggled.
  - `sample_rate` = 2^(RATE_W-1) gives one tick per `next_sample`; 0 gives no ticks.
- **FIFO:**
  - A write is accepted iff `fifo_full` is 0 in that cycle; a write while full is dropped.
  - The read port is a synchronous RAM; data is valid the cycle after the read enable.
  - A write and a read in the same cycle leave the level unchanged.
  - `fifo_reset` empties the FIFO and takes priority over a same-cycle write.
- **Frame size:** F = NUM_CH × (mode_16bit ? 2 : 1) bytes. F and `mode_unsigned` are latched on the IDLE→FETCH transition, so mode changes mid-frame take effect on the next frame.
- **State machine (IDLE, FETCH, COMMIT):**
  - IDLE, `tick`, and `fifo_level` ≥ F: assert read, load byte counter = 0, go to FETCH.
  - IDLE, `tick`, and `fifo_level` < F: set `underrun`; no bytes are consumed, so partial frames are never split. Outputs then take the underrun value (see Configuration). Stay in IDLE.
  - FETCH: capture the byte into slot (channel = counter / bytes-per-sample, low byte first). Increment the counter, and assert read while fewer than F reads have been issued. After capturing byte F-1, go to COMMIT.
  - COMMIT: load all channel output registers simultaneously, then go to IDLE.
  - A `tick` that arrives outside IDLE is dropped.
- **Sample assembly:** 8-bit samples become {byte, 8'h00}. Unsigned mode inverts bit 15 of the assembled sample.
- **Volume:** a 4-bit code maps to signed 9-bit gain 0,2,4,6,8,10,12,16,21,27,35,45,59,76,99,128. The output is the 16×9 signed product, registered, 23 bits, with no saturation. Volume changes apply within 1 cycle even without a new frame.
- **`fifo_reset` during FETCH/COMMIT:** abort to IDLE and discard the partial frame. `audio_out` keeps its prior value, and `underrun` is not set by the abort.
- **`underrun_clr`:** clears `underrun`. If it coincides with a new underrun event, the set wins.

## Timing
- For `next_sample` in cycle 0 that yields a tick:
  - `tick` is high in cycle 1, and the first read is issued in cycle 1.
  - Bytes are captured in cycles 2..F+1; COMMIT is in cycle F+2.
  - The output register updates at the end of cycle F+2.
  - `audio_out` and `sample_valid` change in cycle F+4, so mono 8-bit shows a new value in cycle 5.
- Worst case F=8 uses 11 cycles; `next_sample` spacing is ≥12 cycles by system constraint.
- FIFO flags and `fifo_level` are registered and update the cycle after a write or read.

## Configuration
- `PCM_MC_UNDERRUN_HOLD_EN`:
  - Defined: on underrun or an empty FIFO in IDLE, the output registers hold the last committed frame. `sample_valid` does not pulse.
  - Undefined: on underrun, the output registers are cleared to 0, and `audio_out` reaches 0 two cycles later. `sample_valid` pulses once on that transition.

## Test plan
- Reset: assert `rst_n`=0 mid-FETCH → all outputs at their reset values within the same cycle, and `fifo_level`=0 after release.
- Stereo 16-bit: NUM_CH=2, vol=15, sample_rate=128, write 34 12 CD AB, pulse `next_sample` → in cycle 8, `audio_out` ch0=0x1234×128, ch1=(signed)0xABCD×128, `sample_valid`=1, `fifo_level`=0.
- Unsigned 8-bit: NUM_CH=1, write 0x80, vol=15 → output 0.
- Same stimulus with byte 0xFF → output 0x7F00×128.
- Rate and partial frame:
  - Rate: sample_rate=64 → exactly one frame consumed per two `next_sample` strobes over 16 strobes.
  - Partial frame: NUM_CH=2, 16-bit, 3 bytes queued, tick → `underrun`=1, level stays 3. Output is held with the macro defined and goes to 0 without it.
- Full and flush:
  - Full: write FIFO_DEPTH+1 bytes → `fifo_full`=1, last byte dropped, level=FIFO_DEPTH.
  - Flush: `fifo_reset` during FETCH → state IDLE, level 0, `audio_out` unchanged.
  - Per-channel volume: ch0 vol=0 and ch1 vol=8 → ch0=0, ch1=sample×21.

Source files
------------

// File: rtl/pcm_mc_if.sv
// pcm_mc_if: host-side bus between the register block and the PCM engine.
//   fifo_wrdata/fifo_write  byte write port into the audio FIFO
//   fifo_reset              synchronous FIFO flush
//   underrun_clr            clears the sticky underrun flag
//   fifo_full/empty/almost_empty, fifo_level, underrun  status back to host
// master = register/bus side, slave = pcm_mc.
interface pcm_mc_if #(
  parameter int FIFO_DEPTH = 4096
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             fifo_reset;
  logic [7:0]       fifo_wrdata;
  logic             fifo_write;
  logic             underrun_clr;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_almost_empty;
  logic [LVL_W-1:0] fifo_level;
  logic             underrun;

  modport master (
    output fifo_reset, fifo_wrdata, fifo_write, underrun_clr,
    input  fifo_full, fifo_empty, fifo_almost_empty, fifo_level, underrun
  );

  modport slave (
    input  fifo_reset, fifo_wrdata, fifo_write, underrun_clr,
    output fifo_full, fifo_empty, fifo_almost_empty, fifo_level, underrun
  );
endinterface

// File: rtl/pcm_mc.sv
// pcm_mc: multi-channel PCM playback engine.
// Host bytes fill a FIFO; a rate accumulator clocked by next_sample produces
// ticks, each tick pops one whole frame (NUM_CH samples of 8/16 bit) which is
// scaled by a per-channel log volume and presented on audio_out.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   next_sample          DAC base-rate strobe
//   sample_rate          accumulator increment
//   mode_16bit           1: 16-bit LE samples, 0: 8-bit
//   mode_unsigned        1: offset-binary samples (MSB flipped)
//   volume               4 bits per channel
//   host                 pcm_mc_if.slave (FIFO write/flush, status, underrun)
//   sample_valid         pulse in the first cycle of a new audio_out value
//   audio_out            23 bits signed per channel
// Build option: PCM_MC_UNDERRUN_HOLD_EN -- when defined, an underrun keeps the
// last committed frame instead of zeroing the outputs.

// Per-channel output lane: sample register, gain LUT, registered product.
module pcm_mc_lane (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clr,
  input  logic        uns,
  input  logic [15:0] raw,
  input  logic [3:0]  vol,
  output logic [22:0] audio
);
  logic [15:0] samp_q, samp_d;
  logic [22:0] out_q, out_d;
  logic [8:0]  gain;

  always_comb begin
    case (vol)
      4'd0:  gain = 9'd0;
      4'd1:  gain = 9'd2;
      4'd2:  gain = 9'd4;
      4'd3:  gain = 9'd6;
      4'd4:  gain = 9'd8;
      4'd5:  gain = 9'd10;
      4'd6:  gain = 9'd12;
      4'd7:  gain = 9'd16;
      4'd8:  gain = 9'd21;
      4'd9:  gain = 9'd27;
      4'd10: gain = 9'd35;
      4'd11: gain = 9'd45;
      4'd12: gain = 9'd59;
      4'd13: gain = 9'd76;
      4'd14: gain = 9'd99;
      default: gain = 9'd128;
    endcase
  end

  always_comb begin
    samp_d = samp_q;
    if (clr)       samp_d = '0;
    else if (load) samp_d = raw ^ {uns, 15'b0};
    // Sign-extend both operands to 23 bits; the low 23 bits of the unsigned
    // product equal the signed product, which always fits without saturation.
    out_d = {{7{samp_q[15]}}, samp_q} * {{14{gain[8]}}, gain};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q <= '0;
      out_q  <= '0;
    end else begin
      samp_q <= samp_d;
      out_q  <= out_d;
    end
  end

  assign audio = out_q;
endmodule

module pcm_mc #(
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4096,
  parameter int RATE_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  next_sample,
  input  logic [RATE_W-1:0]     sample_rate,
  input  logic                  mode_16bit,
  input  logic                  mode_unsigned,
  input  logic [4*NUM_CH-1:0]   volume,
  pcm_mc_if.slave               host,
  output logic                  sample_valid,
  output logic [23*NUM_CH-1:0]  audio_out
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;

  typedef enum logic [1:0] {IDLE, FETCH, COMMIT} state_t;

  // ---------------- rate accumulator ----------------
  logic [RATE_W-1:0] acc_q, acc_d;
  logic              tick_q, tick_d;

  always_comb begin
    acc_d  = next_sample ? acc_q + sample_rate : acc_q;
    tick_d = next_sample & (acc_d[RATE_W-1] ^ acc_q[RATE_W-1]);
  end

  // ---------------- FIFO ----------------
  logic [7:0]       mem [FIFO_DEPTH];
  logic [7:0]       rd_data_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, full_d, empty_q, empty_d, ae_q, ae_d;
  logic             wr_en, rd_en;

  assign wr_en = host.fifo_write & ~full_q & ~host.fifo_reset;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    level_d  = level_q + LVL_W'(wr_en) - LVL_W'(rd_en);
    if (host.fifo_reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
    full_d  = (level_d == LVL_W'(FIFO_DEPTH));
    empty_d = (level_d == '0);
    ae_d    = (level_d < LVL_W'(FIFO_DEPTH / 4));
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= host.fifo_wrdata;
    if (rd_en) rd_data_q     <= mem[rd_ptr_q];
  end

  // ---------------- frame FSM ----------------
  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d, fb_q, fb_d, fsize, ch_idx;
  logic                    m16_q, m16_d, uns_q, uns_d;
  logic [NUM_CH-1:0][15:0] frm_q, frm_d;
  logic                    commit, out_clr, ur_set;
  logic                    ur_q, ur_d;
  logic [1:0]              vld_pipe_q;

  assign fsize = mode_16bit ? 4'(2 * NUM_CH) : 4'(NUM_CH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fb_d    = fb_q;
    m16_d   = m16_q;
    uns_d   = uns_q;
    frm_d   = frm_q;
    rd_en   = 1'b0;
    commit  = 1'b0;
    out_clr = 1'b0;
    ur_set  = 1'b0;
    ch_idx  = m16_q ? {1'b0, cnt_q[3:1]} : cnt_q;
    case (state_q)
      IDLE: begin
        if (tick_q && !host.fifo_reset) begin
          if (level_q >= LVL_W'(fsize)) begin
            rd_en   = 1'b1;
            cnt_d   = '0;
            fb_d    = fsize;
            m16_d   = mode_16bit;
            uns_d   = mode_unsigned;
            state_d = FETCH;
          end else begin
            // Never split a partial frame: consume nothing, flag underrun.
            ur_set = 1'b1;
`ifdef PCM_MC_UNDERRUN_HOLD_EN
            out_clr = 1'b0;
`else
            out_clr = 1'b1;
`endif
          end
        end
      end
      FETCH: begin
        if (host.fifo_reset) begin
          state_d = IDLE;
        end else begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (ch_idx == 4'(c)) begin
              if (!m16_q)       frm_d[c]       = {rd_data_q, 8'h00};
              else if (cnt_q[0]) frm_d[c][15:8] = rd_data_q;
              else               frm_d[c][7:0]  = rd_data_q;
            end
          end
          cnt_d = cnt_q + 4'd1;
          // Reads run one ahead of captures; stop once F have been issued.
          if ((cnt_q + 4'd1) < fb_q) rd_en = 1'b1;
          if (cnt_q == (fb_q - 4'd1)) state_d = COMMIT;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (!host.fifo_reset) commit = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    ur_d = ur_set ? 1'b1 : (host.underrun_clr ? 1'b0 : ur_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      tick_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ae_q       <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      fb_q       <= '0;
      m16_q      <= 1'b0;
      uns_q      <= 1'b0;
      frm_q      <= '0;
      ur_q       <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      acc_q      <= acc_d;
      tick_q     <= tick_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      ae_q       <= ae_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fb_q       <= fb_d;
      m16_q      <= m16_d;
      uns_q      <= uns_d;
      frm_q      <= frm_d;
      ur_q       <= ur_d;
      // Sample register then product register: new value shows two cycles on.
      vld_pipe_q <= {vld_pipe_q[0], commit | out_clr};
    end
  end

  // ---------------- per-channel lanes ----------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    pcm_mc_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (commit),
      .clr   (out_clr),
      .uns   (uns_q),
      .raw   (frm_q[g]),
      .vol   (volume[4*g +: 4]),
      .audio (audio_out[23*g +: 23])
    );
  end

  assign sample_valid           = vld_pipe_q[1];
  assign host.fifo_full         = full_q;
  assign host.fifo_empty        = empty_q;
  assign host.fifo_almost_empty = ae_q;
  assign host.fifo_level        = level_q;
  assign host.underrun          = ur_q;
endmodule

// File: tb/tb_pcm_mc.sv
module tb_pcm_mc;
  localparam int NUM_CH = 2;
  localparam int DEPTH  = 16;
  localparam int RATE_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              next_sample;
  logic [RATE_W-1:0] sample_rate;
  logic              mode_16bit, mode_unsigned;
  logic [7:0]        volume;
  logic              sample_valid;
  logic [45:0]       audio_out;

  int passed = 0;
  int total  = 0;
  int sv_cnt = 0;

  pcm_mc_if #(.FIFO_DEPTH(DEPTH)) bus ();

  pcm_mc #(.NUM_CH(NUM_CH), .FIFO_DEPTH(DEPTH), .RATE_W(RATE_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .next_sample  (next_sample),
    .sample_rate  (sample_rate),
    .mode_16bit   (mode_16bit),
    .mode_unsigned(mode_unsigned),
    .volume       (volume),
    .host         (bus.slave),
    .sample_valid (sample_valid),
    .audio_out    (audio_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sample_valid === 1'b1) sv_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [22:0] p23(input logic [15:0] s, input int g);
    int v;
    v = int'($signed(s)) * g;
    return v[22:0];
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    bus.fifo_wrdata = b;
    bus.fifo_write  = 1'b1;
    cyc(1);
    bus.fifo_write  = 1'b0;
  endtask

  // Leaves the bench in cycle 1 relative to the strobe.
  task automatic strobe();
    next_sample = 1'b1;
    cyc(1);
    next_sample = 1'b0;
  endtask

  logic [45:0] held;
  int          sv0;

  initial begin
    rst_n = 1'b0; next_sample = 1'b0; sample_rate = 8'd128;
    mode_16bit = 1'b1; mode_unsigned = 1'b0; volume = 8'hFF;
    bus.fifo_reset = 1'b0; bus.fifo_wrdata = 8'h00; bus.fifo_write = 1'b0;
    bus.underrun_clr = 1'b0;
    cyc(2);
    check("rst_empty",  64'(bus.fifo_empty), 64'd1);
    check("rst_ae",     64'(bus.fifo_almost_empty), 64'd1);
    check("rst_full",   64'(bus.fifo_full), 64'd0);
    check("rst_level",  64'(bus.fifo_level), 64'd0);
    check("rst_ur",     64'(bus.underrun), 64'd0);
    check("rst_sv",     64'(sample_valid), 64'd0);
    check("rst_audio",  64'(audio_out), 64'd0);
    rst_n = 1'b1;
    cyc(1);

    // Stereo 16-bit
    wr(8'h34); wr(8'h12); wr(8'hCD); wr(8'hAB);
    check("st_level4", 64'(bus.fifo_level), 64'd4);
    strobe(); cyc(6);
    check("st_sv_c7", 64'(sample_valid), 64'd0);
    cyc(1);
    check("st_sv_c8",  64'(sample_valid), 64'd1);
    check("st_audio",  64'(audio_out), 64'({23'h55E680, 23'h091A00}));
    check("st_level0", 64'(bus.fifo_level), 64'd0);
    check("st_empty",  64'(bus.fifo_empty), 64'd1);
    cyc(1);
    check("st_sv_c9", 64'(sample_valid), 64'd0);

    // Per-channel volume: ch0 code 0, ch1 code 8
    volume = 8'h80;
    cyc(1);
    check("vol_audio", 64'(audio_out), 64'({p23(16'hABCD, 21), 23'h0}));

    // Unsigned 8-bit: 0x80 -> 0, 0xFF -> 0x7F00
    volume = 8'hFF; mode_16bit = 1'b0; mode_unsigned = 1'b1;
    wr(8'h80); wr(8'hFF);
    strobe(); cyc(4);
    check("u8_sv_c5", 64'(sample_valid), 64'd0);
    cyc(1);
    check("u8_sv_c6",  64'(sample_valid), 64'd1);
    check("u8_audio",  64'(audio_out), 64'({23'h3F8000, 23'h000000}));
    held = audio_out;

    // Partial frame: 3 bytes, 16-bit stereo needs 4
    mode_16bit = 1'b1; mode_unsigned = 1'b0;
    wr(8'h11); wr(8'h22); wr(8'h33);
    strobe(); cyc(1);
    check("pf_ur",    64'(bus.underrun), 64'd1);
    check("pf_level", 64'(bus.fifo_level), 64'd3);
    cyc(1);
`ifdef PCM_MC_UNDERRUN_HOLD_EN
    check("pf_audio", 64'(audio_out), 64'(held));
    check("pf_sv",    64'(sample_valid), 64'd0);
`else
    check("pf_audio", 64'(audio_out), 64'd0);
    check("pf_sv",    64'(sample_valid), 64'd1);
`endif
    bus.underrun_clr = 1'b1; cyc(1); bus.underrun_clr = 1'b0;
    check("ur_clr", 64'(bus.underrun), 64'd0);
    bus.fifo_reset = 1'b1; cyc(1); bus.fifo_reset = 1'b0;
    check("flush_level", 64'(bus.fifo_level), 64'd0);
    check("flush_empty", 64'(bus.fifo_empty), 64'd1);
    // Underrun set beats a same-cycle clear
    strobe();
    bus.underrun_clr = 1'b1; cyc(1); bus.underrun_clr = 1'b0;
    check("ur_set_wins", 64'(bus.underrun), 64'd1);
    bus.underrun_clr = 1'b1; cyc(1); bus.underrun_clr = 1'b0;

    // Full: 17 writes into 16 bytes, last dropped
    mode_16bit = 1'b0; sample_rate = 8'd64;
    for (int i = 0; i < DEPTH + 1; i++) wr(8'(i + 1));
    check("full_flag",  64'(bus.fifo_full), 64'd1);
    check("full_level", 64'(bus.fifo_level), 64'd16);
    check("full_ae",    64'(bus.fifo_almost_empty), 64'd0);

    // Rate 64: one frame per two strobes
    sv0 = sv_cnt;
    for (int s = 0; s < 16; s++) begin
      strobe(); cyc(11);
      if (s == 0) check("rate_s1", 64'(bus.fifo_level), 64'd16);
      if (s == 1) check("rate_s2", 64'(bus.fifo_level), 64'd14);
    end
    check("rate_level",  64'(bus.fifo_level), 64'd0);
    check("rate_frames", 64'(sv_cnt - sv0), 64'd8);
    check("rate_ur",     64'(bus.underrun), 64'd0);
    check("rate_audio",  64'(audio_out), 64'({p23(16'h1000, 128), p23(16'h0F00, 128)}));
    held = audio_out;

    // Flush during FETCH
    sample_rate = 8'd128; mode_16bit = 1'b1;
    wr(8'h34); wr(8'h12); wr(8'hCD); wr(8'hAB);
    sv0 = sv_cnt;
    strobe(); cyc(1);
    bus.fifo_reset = 1'b1; cyc(1); bus.fifo_reset = 1'b0;
    cyc(8);
    check("fl_level", 64'(bus.fifo_level), 64'd0);
    check("fl_audio", 64'(audio_out), 64'(held));
    check("fl_ur",    64'(bus.underrun), 64'd0);
    check("fl_nosv",  64'(sv_cnt - sv0), 64'd0);
    wr(8'h34); wr(8'h12); wr(8'hCD); wr(8'hAB);
    strobe(); cyc(7);
    check("fl_restart_sv",    64'(sample_valid), 64'd1);
    check("fl_restart_audio", 64'(audio_out), 64'({23'h55E680, 23'h091A00}));

    // Async reset mid-FETCH
    wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
    strobe(); cyc(1);
    rst_n = 1'b0;
    #1;
    check("ar_audio", 64'(audio_out), 64'd0);
    check("ar_sv",    64'(sample_valid), 64'd0);
    check("ar_level", 64'(bus.fifo_level), 64'd0);
    check("ar_empty", 64'(bus.fifo_empty), 64'd1);
    check("ar_ae",    64'(bus.fifo_almost_empty), 64'd1);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    check("ar_level_rel", 64'(bus.fifo_level), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
